multiport_register_file: RTL and testbench
==========================================

# multiport_register_file

Parametrised general-purpose register file with a configurable number of combinational read ports and one synchronous write port. It adds write-to-read bypass, an optional hardwired-zero register 0, a per-register pending scoreboard for hazard tracking, and a sequenced bulk-clear engine. It sits between the decode stage, which reads operands and reserves destinations, and the writeback stage, which writes results.

## Interface
- ADDR_WIDTH, 3, register address width; REG_N = 2**ADDR_WIDTH registers (localparam)
- REG_WIDTH, 16, data width of each register
- READ_PORTS, 2, number of independent read ports (>= 1)
- ZERO_REG, 1, if 1, register 0 always reads 0 and is never written or pending
- BYPASS, 1, if 1, a same-cycle write is forwarded to matching read ports

Ports:
- clk  input  1  rising-edge clock; the only clock
- reset_n  input  1  reset, asynchronous and active-low
- read_addr  input  READ_PORTS*ADDR_WIDTH  port p address at [p*ADDR_WIDTH +: ADDR_WIDTH]
- read_bus  output  READ_PORTS*REG_WIDTH  port p data at [p*REG_WIDTH +: REG_WIDTH]
- read_ready  output  READ_PORTS  port p operand is not pending (or is bypassed)
- write_enabled  input  1  write request this cycle
- write_addr  input  ADDR_WIDTH  write destination
- write_bus  input  REG_WIDTH  write data
- reserve_enabled  input  1  mark reserve_addr pending
- reserve_addr  input  ADDR_WIDTH  register to reserve
- clear_start  input  1  start bulk clear (level-sampled)
- clear_busy  output  1  bulk clear in progress
- pending  output  REG_N  scoreboard, one bit per register

## Operation
- Reset (reset_n low, asynchronous): all registers 0, pending 0, FSM IDLE, clear counter 0. Resulting outputs: clear_busy 0, read_ready all 1, read_bus 0.
- Write: at the rising edge, if write_enabled and state IDLE, register[write_addr] <= write_bus. The same edge clears pending[write_addr].
- Register 0 with ZERO_REG=1: writes are dropped, reserves are dropped, reads return 0, and pending[0] stays 0.
- Read: combinational. read_bus[p] = register[read_addr[p]].
- Bypass (BYPASS=1, state IDLE, write_enabled, write_addr == read_addr[p], and the address is not a zero register): read_bus[p] = write_bus.
- read_ready[p] = !pending[read_addr[p]], OR-ed with the bypass-match condition when BYPASS=1.
- Reserve: at the edge, if reserve_enabled and state IDLE, pending[reserve_addr] <= 1.
- Reserve and write to the same address at the same edge: the reserve wins. pending stays 1 and the data is still written.
- FSM has two states:
  - IDLE: clear_start high moves to CLEAR, sets the counter to 0, and clears all pending bits at that edge.
  - CLEAR: each edge writes register[counter] <= 0 and increments the counter. On the edge that clears register REG_N-1, the FSM returns to IDLE and the counter wraps to 0.
- While in CLEAR:
  - write_enabled, reserve_enabled and clear_start are ignored.
  - Bypass is inactive.
  - Reads return the current, partially cleared contents.
- clear_busy = (state == CLEAR).

## Timing
- Read latency: 0 cycles (combinational). Write is visible through the array one cycle after the edge, or in the same cycle via bypass.
- Scoreboard: a reserve at edge k makes pending 1 and read_ready 0 after edge k. A write at edge m makes pending 0 after edge m; with BYPASS=1, read_ready is already 1 during the cycle before edge m.
- Bulk clear:
  - clear_start sampled at edge k: clear_busy is 1 from k until edge k+REG_N.
  - register i is zero after edge k+1+i.
  - The first new write is accepted at edge k+REG_N+1.
- reset_n asserted mid-clear: the FSM returns to IDLE immediately. After release, operation restarts with an empty scoreboard.
- reset_n release must be synchronised externally to clk. The block adds no release synchroniser.

## Structure
- A shared package rf_pkg holds the state enum rf_state_t {RF_IDLE, RF_CLEAR} and the helper localparam for REG_N.
- One sub-module, rf_clear_sequencer, owns the FSM and counter. It outputs clear_busy, clear_we and clear_addr, and is muxed into the array write path.
- Read ports are built with a generate loop over READ_PORTS. Each port has its own address compare for bypass and ready.

## Test plan
- Reset, then write r3=0xBEEF, r5=0x1234; read ports 0/1 on r3/r5 -> 0xBEEF/0x1234, read_ready 2'b11.
- ZERO_REG=1: write r0=0xFFFF and reserve r0 -> read r0 is 0x0000, pending[0]=0, read_ready=1.
- BYPASS=1: same-cycle write r2=0xA5A5 with read_addr[0]=2 -> read_bus[0]=0xA5A5 before the edge. Repeat with BYPASS=0 -> old value returned.
- Reserve r4 -> pending=8'h10, read_ready for r4 is 0. Reserve and write r4 at the same edge -> pending[4] stays 1 and r4 holds the new data. A later write clears pending[4].
- Fill all 8 registers with nonzero values, pulse clear_start -> clear_busy high exactly 8 cycles, r_i zero after edge k+1+i, and writes during busy are ignored.
- Assert reset_n low during cycle 3 of a clear -> clear_busy 0 immediately, all registers 0 and pending 0 after release.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and sizing helpers for the multiport register file.
// Holds the clear-engine state encoding and the register-count helper.
package rf_pkg;

  typedef enum logic {
    RF_IDLE,
    RF_CLEAR
  } rf_state_t;

  localparam int RF_DEFAULT_ADDR_WIDTH = 3;
  localparam int RF_DEFAULT_REG_N      = 2 ** RF_DEFAULT_ADDR_WIDTH;

  function automatic int reg_count(input int addr_width);
    return 2 ** addr_width;
  endfunction

endpackage

// File: rtl/rf_clear_sequencer.sv
// Bulk-clear engine: walks every register address once, emitting a zero
// write per cycle, then drops back to idle.
import rf_pkg::*;

module rf_clear_sequencer #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  clear_we,
  output logic [ADDR_WIDTH-1:0] clear_addr
);

  rf_state_t             state, next_state;
  logic [ADDR_WIDTH-1:0] counter, next_counter;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RF_IDLE;
      counter <= '0;
    end else begin
      state   <= next_state;
      counter <= next_counter;
    end
  end

  // The counter wraps naturally to 0 on the same edge that clears the last register.
  always_comb begin
    next_state   = state;
    next_counter = counter;
    case (state)
      RF_IDLE: begin
        if (clear_start) begin
          next_state   = RF_CLEAR;
          next_counter = '0;
        end
      end
      RF_CLEAR: begin
        next_counter = counter + 1'b1;
        if (counter == '1) next_state = RF_IDLE;
      end
      default: next_state = RF_IDLE;
    endcase
  end

  assign clear_busy = (state == RF_CLEAR);
  assign clear_we   = (state == RF_CLEAR);
  assign clear_addr = counter;

endmodule

// File: rtl/multiport_register_file.sv
// Register file with N combinational read ports, one write port, write-to-read
// bypass, optional hardwired-zero r0, pending scoreboard and bulk clear.
import rf_pkg::*;

module multiport_register_file #(
  parameter int ADDR_WIDTH = 3,
  parameter int REG_WIDTH  = 16,
  parameter int READ_PORTS = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_addr,
  output logic [READ_PORTS*REG_WIDTH-1:0]  read_bus,
  output logic [READ_PORTS-1:0]            read_ready,
  input  logic                             write_enabled,
  input  logic [ADDR_WIDTH-1:0]            write_addr,
  input  logic [REG_WIDTH-1:0]             write_bus,
  input  logic                             reserve_enabled,
  input  logic [ADDR_WIDTH-1:0]            reserve_addr,
  input  logic                             clear_start,
  output logic                             clear_busy,
  output logic [reg_count(ADDR_WIDTH)-1:0] pending
);

  localparam int REG_N = reg_count(ADDR_WIDTH);

  logic [REG_WIDTH-1:0]  regs [REG_N];
  logic                  idle;
  logic                  clear_launch;
  logic                  user_write;
  logic                  clear_we;
  logic [ADDR_WIDTH-1:0] clear_addr;
  logic                  array_we;
  logic [ADDR_WIDTH-1:0] array_addr;
  logic [REG_WIDTH-1:0]  array_data;

  function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  rf_clear_sequencer #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clear_sequencer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear_start(clear_start),
    .clear_busy (clear_busy),
    .clear_we   (clear_we),
    .clear_addr (clear_addr)
  );

  assign idle         = !clear_busy;
  assign clear_launch = idle && clear_start;
  assign user_write   = idle && write_enabled && !is_zero_reg(write_addr);

  // The clear engine owns the write path while busy; user writes are dropped then.
  always_comb begin
    array_we   = user_write;
    array_addr = write_addr;
    array_data = write_bus;
    if (clear_we) begin
      array_we   = 1'b1;
      array_addr = clear_addr;
      array_data = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (array_we) begin
      regs[array_addr] <= array_data;
    end
  end

  // Reserve is applied after the write-clear so it wins on a same-address collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
    end else if (clear_launch) begin
      pending <= '0;
    end else if (idle) begin
      if (write_enabled && !is_zero_reg(write_addr)) pending[write_addr] <= 1'b0;
      if (reserve_enabled && !is_zero_reg(reserve_addr)) pending[reserve_addr] <= 1'b1;
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
    logic [ADDR_WIDTH-1:0] addr;
    logic                  hit;
    logic [REG_WIDTH-1:0]  data;

    assign addr = read_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign hit  = (BYPASS != 0) && idle && write_enabled &&
                  (write_addr == addr) && !is_zero_reg(addr);

    always_comb begin
      data = regs[addr];
      if (is_zero_reg(addr)) data = '0;
      else if (hit)          data = write_bus;
    end

    assign read_bus[p*REG_WIDTH +: REG_WIDTH] = data;
    assign read_ready[p] = !pending[addr] || hit;
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed self-checking bench for multiport_register_file; a second
// instance with bypass disabled shares the stimulus for comparison.
module tb_multiport_register_file;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [5:0]  read_addr = '0;
  logic [31:0] read_bus, nb_read_bus;
  logic [1:0]  read_ready, nb_read_ready;
  logic        write_enabled = 1'b0;
  logic [2:0]  write_addr = '0;
  logic [15:0] write_bus = '0;
  logic        reserve_enabled = 1'b0;
  logic [2:0]  reserve_addr = '0;
  logic        clear_start = 1'b0;
  logic        clear_busy, nb_clear_busy;
  logic [7:0]  pending, nb_pending;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] fill [8];

  always #5 clk = ~clk;

  multiport_register_file #(.BYPASS(1)) dut (
    .clk(clk), .reset_n(reset_n), .read_addr(read_addr), .read_bus(read_bus),
    .read_ready(read_ready), .write_enabled(write_enabled), .write_addr(write_addr),
    .write_bus(write_bus), .reserve_enabled(reserve_enabled), .reserve_addr(reserve_addr),
    .clear_start(clear_start), .clear_busy(clear_busy), .pending(pending)
  );

  multiport_register_file #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset_n(reset_n), .read_addr(read_addr), .read_bus(nb_read_bus),
    .read_ready(nb_read_ready), .write_enabled(write_enabled), .write_addr(write_addr),
    .write_bus(write_bus), .reserve_enabled(reserve_enabled), .reserve_addr(reserve_addr),
    .clear_start(clear_start), .clear_busy(nb_clear_busy), .pending(nb_pending)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_reads(input logic [2:0] a0, input logic [2:0] a1);
    read_addr = {a1, a0};
    #1;
  endtask

  initial begin
    // Reset state
    #1 reset_n = 1'b0;
    #2;
    check_output("reset_busy", {31'd0, clear_busy}, 32'd0);
    check_output("reset_ready", {30'd0, read_ready}, 32'd3);
    check_output("reset_bus", read_bus, 32'd0);
    check_output("reset_pending", {24'd0, pending}, 32'd0);
    step();
    reset_n = 1'b1;
    step();

    // Basic writes and reads
    write_enabled = 1'b1; write_addr = 3'd3; write_bus = 16'hBEEF;
    step();
    write_addr = 3'd5; write_bus = 16'h1234;
    step();
    write_enabled = 1'b0;
    set_reads(3'd3, 3'd5);
    check_output("read_r3_r5", read_bus, 32'h1234_BEEF);
    check_output("ready_r3_r5", {30'd0, read_ready}, 32'd3);

    // Hardwired zero register
    write_enabled = 1'b1; write_addr = 3'd0; write_bus = 16'hFFFF;
    reserve_enabled = 1'b1; reserve_addr = 3'd0;
    set_reads(3'd0, 3'd5);
    check_output("r0_no_bypass", {16'd0, read_bus[15:0]}, 32'd0);
    step();
    write_enabled = 1'b0; reserve_enabled = 1'b0;
    set_reads(3'd0, 3'd5);
    check_output("r0_read", {16'd0, read_bus[15:0]}, 32'd0);
    check_output("r0_pending", {24'd0, pending}, 32'd0);
    check_output("r0_ready", {31'd0, read_ready[0]}, 32'd1);

    // Same-cycle bypass, with and without BYPASS
    write_enabled = 1'b1; write_addr = 3'd2; write_bus = 16'hA5A5;
    set_reads(3'd2, 3'd5);
    check_output("bypass_data", {16'd0, read_bus[15:0]}, 32'h0000_A5A5);
    check_output("nobypass_data", {16'd0, nb_read_bus[15:0]}, 32'h0000_0000);
    step();
    write_enabled = 1'b0;
    set_reads(3'd2, 3'd5);
    check_output("r2_after_write", read_bus, 32'h1234_A5A5);
    check_output("nb_r2_after_write", nb_read_bus, 32'h1234_A5A5);

    // Scoreboard: reserve, reserve+write collision, releasing write
    reserve_enabled = 1'b1; reserve_addr = 3'd4;
    step();
    reserve_enabled = 1'b0;
    set_reads(3'd2, 3'd4);
    check_output("reserve_pending", {24'd0, pending}, 32'h10);
    check_output("reserve_ready", {30'd0, read_ready}, 32'd1);
    reserve_enabled = 1'b1; write_enabled = 1'b1; write_addr = 3'd4; write_bus = 16'h4444;
    step();
    reserve_enabled = 1'b0; write_enabled = 1'b0;
    set_reads(3'd2, 3'd4);
    check_output("collide_pending", {24'd0, pending}, 32'h10);
    check_output("collide_data", {16'd0, read_bus[31:16]}, 32'h4444);
    write_enabled = 1'b1; write_addr = 3'd4; write_bus = 16'h5555;
    set_reads(3'd2, 3'd4);
    check_output("release_ready_early", {30'd0, read_ready}, 32'd3);
    check_output("nb_release_ready_early", {30'd0, nb_read_ready}, 32'd1);
    step();
    write_enabled = 1'b0;
    set_reads(3'd2, 3'd4);
    check_output("release_pending", {24'd0, pending}, 32'h00);
    check_output("release_data", {16'd0, read_bus[31:16]}, 32'h5555);

    // Bulk clear
    fill[0] = 16'h0000;
    for (int i = 1; i < 8; i++) begin
      fill[i] = 16'(16'h1111 * i);
      write_enabled = 1'b1; write_addr = 3'(i); write_bus = fill[i];
      step();
    end
    write_enabled = 1'b0;
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    write_enabled = 1'b1; write_addr = 3'd7; write_bus = 16'hDEAD;
    reserve_enabled = 1'b1; reserve_addr = 3'd6;
    for (int j = 0; j < 8; j++) begin
      set_reads(3'(j), 3'(j - 1));
      check_output($sformatf("clear_busy_%0d", j), {31'd0, clear_busy}, 32'd1);
      check_output($sformatf("clear_pend_%0d", j), {24'd0, pending}, 32'd0);
      check_output($sformatf("clear_keep_r%0d", j), {16'd0, read_bus[15:0]}, {16'd0, fill[j]});
      if (j > 0)
        check_output($sformatf("clear_zero_r%0d", j - 1), {16'd0, read_bus[31:16]}, 32'd0);
      step();
    end
    write_enabled = 1'b0; reserve_enabled = 1'b0;
    check_output("clear_done_busy", {31'd0, clear_busy}, 32'd0);
    check_output("clear_done_pending", {24'd0, pending}, 32'd0);
    for (int j = 0; j < 8; j += 2) begin
      set_reads(3'(j), 3'(j + 1));
      check_output($sformatf("clear_done_r%0d", j), read_bus, 32'd0);
    end
    write_enabled = 1'b1; write_addr = 3'd7; write_bus = 16'h7E7E;
    step();
    write_enabled = 1'b0;
    set_reads(3'd7, 3'd6);
    check_output("first_write_after_clear", read_bus, 32'h0000_7E7E);

    // Reset asserted mid-clear
    write_enabled = 1'b1; write_addr = 3'd1; write_bus = 16'h0A0A;
    step();
    write_addr = 3'd2; write_bus = 16'h0B0B;
    reserve_enabled = 1'b1; reserve_addr = 3'd5;
    step();
    write_enabled = 1'b0; reserve_enabled = 1'b0;
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    step();
    step();
    check_output("midclear_busy", {31'd0, clear_busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_output("midclear_reset_busy", {31'd0, clear_busy}, 32'd0);
    step();
    step();
    reset_n = 1'b1;
    set_reads(3'd1, 3'd2);
    check_output("post_reset_r1_r2", read_bus, 32'd0);
    check_output("post_reset_pending", {24'd0, pending}, 32'd0);
    set_reads(3'd5, 3'd7);
    check_output("post_reset_r5_r7", read_bus, 32'd0);
    check_output("post_reset_ready", {30'd0, read_ready}, 32'd3);
    write_enabled = 1'b1; write_addr = 3'd1; write_bus = 16'h0101;
    step();
    write_enabled = 1'b0;
    set_reads(3'd1, 3'd0);
    check_output("post_reset_write", read_bus, 32'h0000_0101);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
